// File: rtl/fric_protocol_monitor.sv
// FRIC link protocol monitor: two byte-serial packet parsers (requests on
// fric_out, acknowledges on fric_in), outstanding-transaction tracking,
// saturating statistics counters and sticky protocol-error flags.

module fric_parser #(
    parameter int ADDR_BYTES = 2,
    parameter int DATA_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              i_byte,
    output logic                    o_done,
    output logic [3:0]              o_done_type,
    output logic                    o_bad_type,
    output logic                    o_pkt_valid,
    output logic [3:0]              o_pkt_type,
    output logic [3:0]              o_pkt_port,
    output logic [8*ADDR_BYTES-1:0] o_pkt_addr,
    output logic [8*DATA_BYTES-1:0] o_pkt_data
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_cnt;
    logic [3:0]      r_type, r_port;
    logic [AW-1:0]   r_addr, w_addr_shift;
    logic [DW-1:0]   r_data, w_data_shift;
    logic            r_pkt_valid;
    logic [3:0]      r_pkt_type, r_pkt_port;
    logic [AW-1:0]   r_pkt_addr;
    logic [DW-1:0]   r_pkt_data;
    logic            w_hdr_legal, w_has_data, w_addr_last, w_data_last;
    logic            w_hdr_accept, w_done, w_bad_type;

    assign w_hdr_legal  = (i_byte[7:4] >= 4'd1) && (i_byte[7:4] <= 4'd4);
    assign w_has_data   = (r_type == 4'd1) || (r_type == 4'd3);
    assign w_addr_last  = (r_cnt == 3'(ADDR_BYTES - 1));
    assign w_data_last  = (r_cnt == 3'(DATA_BYTES - 1));
    assign w_addr_shift = (r_addr << 8) | AW'(i_byte);
    assign w_data_shift = (r_data << 8) | DW'(i_byte);

    // State register.
    // NOTE: sequential state uses <= so every flop samples pre-edge values; comb logic uses =.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode: header -> address phase -> optional data phase -> idle.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (i_byte != 8'h00 && w_hdr_legal) w_state_nxt = S_ADDR;
            S_ADDR:  if (w_addr_last) w_state_nxt = w_has_data ? S_DATA : S_IDLE;
            S_DATA:  if (w_data_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: header accept, bad-type event, and packet completion.
    always_comb begin
        w_hdr_accept = 1'b0;
        w_bad_type   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: if (i_byte != 8'h00) begin
                        w_hdr_accept = w_hdr_legal;
                        w_bad_type   = !w_hdr_legal;
                    end
            S_ADDR:  w_done = w_addr_last && !w_has_data;
            S_DATA:  w_done = w_data_last;
            default: ;
        endcase
    end

    // Working registers: latch header, shift in address and data bytes MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_type <= '0;
            r_port <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_hdr_accept) begin
            r_type <= i_byte[7:4];
            r_port <= i_byte[3:0];
            r_addr <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_ADDR) begin
            r_addr <= w_addr_shift;
            r_cnt  <= w_addr_last ? 3'd0 : r_cnt + 3'd1;
        end else if (r_state == S_DATA) begin
            r_data <= w_data_shift;
            r_cnt  <= r_cnt + 3'd1;
        end
    end

    // Completed-packet registers: one-cycle valid, fields hold until next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_valid <= 1'b0;
            r_pkt_type  <= '0;
            r_pkt_port  <= '0;
            r_pkt_addr  <= '0;
            r_pkt_data  <= '0;
        end else begin
            r_pkt_valid <= w_done;
            if (w_done) begin
                r_pkt_type <= r_type;
                r_pkt_port <= r_port;
                r_pkt_addr <= (r_state == S_ADDR) ? w_addr_shift : r_addr;
                r_pkt_data <= (r_state == S_DATA) ? w_data_shift : r_data;
            end
        end
    end

    assign o_done      = w_done;
    assign o_done_type = r_type;
    assign o_bad_type  = w_bad_type;
    assign o_pkt_valid = r_pkt_valid;
    assign o_pkt_type  = r_pkt_type;
    assign o_pkt_port  = r_pkt_port;
    assign o_pkt_addr  = r_pkt_addr;
    assign o_pkt_data  = r_pkt_data;
endmodule

module fric_protocol_monitor #(
    parameter int ADDR_BYTES = 2,
    parameter int DATA_BYTES = 2,
    parameter int CNT_W      = 16,
    parameter int MAX_OUT    = 4,
    parameter int OUT_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [7:0]              fric_out,
    input  logic [7:0]              fric_in,
    output logic                    o_pkt_valid,
    output logic [3:0]              o_pkt_type,
    output logic [3:0]              o_pkt_port,
    output logic [8*ADDR_BYTES-1:0] o_pkt_addr,
    output logic [8*DATA_BYTES-1:0] o_pkt_data,
    output logic                    i_pkt_valid,
    output logic [3:0]              i_pkt_type,
    output logic [3:0]              i_pkt_port,
    output logic [8*ADDR_BYTES-1:0] i_pkt_addr,
    output logic [8*DATA_BYTES-1:0] i_pkt_data,
    output logic [CNT_W-1:0]        wr_req_cnt,
    output logic [CNT_W-1:0]        rd_req_cnt,
    output logic [CNT_W-1:0]        wr_ack_cnt,
    output logic [CNT_W-1:0]        rd_ack_cnt,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [OUT_W-1:0]        outstanding,
    output logic                    err_type,
    output logic                    err_dir,
    output logic                    err_orphan,
    output logic                    err_overflow
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;

    // Stream 0 is fric_out (requests), stream 1 is fric_in (acknowledges).
    logic [7:0]    w_byte  [2];
    logic          w_done  [2];
    logic          w_bad   [2];
    logic          w_valid [2];
    logic [3:0]    w_dtype [2];
    logic [3:0]    w_type  [2];
    logic [3:0]    w_port  [2];
    logic [AW-1:0] w_addr  [2];
    logic [DW-1:0] w_data  [2];

    assign w_byte[0] = fric_out;
    assign w_byte[1] = fric_in;

    for (genvar g = 0; g < 2; g++) begin : g_parser
        fric_parser #(.ADDR_BYTES(ADDR_BYTES), .DATA_BYTES(DATA_BYTES)) u_parser (
            .clk         (clk),
            .rst         (rst),
            .i_byte      (w_byte[g]),
            .o_done      (w_done[g]),
            .o_done_type (w_dtype[g]),
            .o_bad_type  (w_bad[g]),
            .o_pkt_valid (w_valid[g]),
            .o_pkt_type  (w_type[g]),
            .o_pkt_port  (w_port[g]),
            .o_pkt_addr  (w_addr[g]),
            .o_pkt_data  (w_data[g])
        );
    end

    assign o_pkt_valid = w_valid[0];
    assign o_pkt_type  = w_type[0];
    assign o_pkt_port  = w_port[0];
    assign o_pkt_addr  = w_addr[0];
    assign o_pkt_data  = w_data[0];
    assign i_pkt_valid = w_valid[1];
    assign i_pkt_type  = w_type[1];
    assign i_pkt_port  = w_port[1];
    assign i_pkt_addr  = w_addr[1];
    assign i_pkt_data  = w_data[1];

    logic [CNT_W-1:0] r_wr_req_cnt, r_rd_req_cnt, r_wr_ack_cnt, r_rd_ack_cnt, r_err_cnt;
    logic [OUT_W-1:0] r_out, w_out_nxt;
    logic             r_err_type, r_err_dir, r_err_orphan, r_err_overflow;
    logic             w_req, w_ack, w_ev_type, w_ev_dir, w_ev_orphan, w_ev_overflow, w_ev_any;

    // Only direction-correct completions count as transactions.
    assign w_req     = w_done[0] && (w_dtype[0] == 4'd1 || w_dtype[0] == 4'd2);
    assign w_ack     = w_done[1] && (w_dtype[1] == 4'd3 || w_dtype[1] == 4'd4);
    assign w_ev_type = w_bad[0] || w_bad[1];
    assign w_ev_dir  = (w_done[0] && !w_req) || (w_done[1] && !w_ack);
    assign w_ev_any  = w_ev_type || w_ev_dir || w_ev_orphan || w_ev_overflow;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Outstanding update: a simultaneous request and ack cancel out with no error.
    always_comb begin
        w_out_nxt     = r_out;
        w_ev_orphan   = 1'b0;
        w_ev_overflow = 1'b0;
        if (w_req && !w_ack) begin
            if (r_out == OUT_W'(MAX_OUT)) w_ev_overflow = 1'b1;
            else                          w_out_nxt = r_out + 1'b1;
        end else if (w_ack && !w_req) begin
            if (r_out == '0) w_ev_orphan = 1'b1;
            else             w_out_nxt = r_out - 1'b1;
        end
    end

    // Statistics and sticky flags; clear beats any same-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out          <= '0;
            r_wr_req_cnt   <= '0;
            r_rd_req_cnt   <= '0;
            r_wr_ack_cnt   <= '0;
            r_rd_ack_cnt   <= '0;
            r_err_cnt      <= '0;
            r_err_type     <= 1'b0;
            r_err_dir      <= 1'b0;
            r_err_orphan   <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            if (clear) begin
                r_wr_req_cnt   <= '0;
                r_rd_req_cnt   <= '0;
                r_wr_ack_cnt   <= '0;
                r_rd_ack_cnt   <= '0;
                r_err_cnt      <= '0;
                r_err_type     <= 1'b0;
                r_err_dir      <= 1'b0;
                r_err_orphan   <= 1'b0;
                r_err_overflow <= 1'b0;
            end else begin
                if (w_req && w_dtype[0] == 4'd1) r_wr_req_cnt <= sat_inc(r_wr_req_cnt);
                if (w_req && w_dtype[0] == 4'd2) r_rd_req_cnt <= sat_inc(r_rd_req_cnt);
                if (w_ack && w_dtype[1] == 4'd4) r_wr_ack_cnt <= sat_inc(r_wr_ack_cnt);
                if (w_ack && w_dtype[1] == 4'd3) r_rd_ack_cnt <= sat_inc(r_rd_ack_cnt);
                if (w_ev_any)      r_err_cnt      <= sat_inc(r_err_cnt);
                if (w_ev_type)     r_err_type     <= 1'b1;
                if (w_ev_dir)      r_err_dir      <= 1'b1;
                if (w_ev_orphan)   r_err_orphan   <= 1'b1;
                if (w_ev_overflow) r_err_overflow <= 1'b1;
            end
        end
    end

    assign outstanding  = r_out;
    assign wr_req_cnt   = r_wr_req_cnt;
    assign rd_req_cnt   = r_rd_req_cnt;
    assign wr_ack_cnt   = r_wr_ack_cnt;
    assign rd_ack_cnt   = r_rd_ack_cnt;
    assign err_cnt      = r_err_cnt;
    assign err_type     = r_err_type;
    assign err_dir      = r_err_dir;
    assign err_orphan   = r_err_orphan;
    assign err_overflow = r_err_overflow;
endmodule

// File: tb/tb_fric_protocol_monitor.sv
// Testbench for fric_protocol_monitor: a packet-level reference model checked
// against the DUT every cycle, plus hand-computed literal expectations.

module tb_fric_protocol_monitor;
    localparam int AB = 2;
    localparam int DB = 2;
    localparam int CW = 4;
    localparam int MO = 4;
    localparam int OW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst, clear;
    logic [7:0]      fric_out, fric_in;
    logic            o_pkt_valid, i_pkt_valid;
    logic [3:0]      o_pkt_type, o_pkt_port, i_pkt_type, i_pkt_port;
    logic [8*AB-1:0] o_pkt_addr, i_pkt_addr;
    logic [8*DB-1:0] o_pkt_data, i_pkt_data;
    logic [CW-1:0]   wr_req_cnt, rd_req_cnt, wr_ack_cnt, rd_ack_cnt, err_cnt;
    logic [OW-1:0]   outstanding;
    logic            err_type, err_dir, err_orphan, err_overflow;

    always #5 clk = ~clk;

    fric_protocol_monitor #(.ADDR_BYTES(AB), .DATA_BYTES(DB), .CNT_W(CW),
                            .MAX_OUT(MO), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .fric_out(fric_out), .fric_in(fric_in),
        .o_pkt_valid(o_pkt_valid), .o_pkt_type(o_pkt_type), .o_pkt_port(o_pkt_port),
        .o_pkt_addr(o_pkt_addr), .o_pkt_data(o_pkt_data),
        .i_pkt_valid(i_pkt_valid), .i_pkt_type(i_pkt_type), .i_pkt_port(i_pkt_port),
        .i_pkt_addr(i_pkt_addr), .i_pkt_data(i_pkt_data),
        .wr_req_cnt(wr_req_cnt), .rd_req_cnt(rd_req_cnt), .wr_ack_cnt(wr_ack_cnt),
        .rd_ack_cnt(rd_ack_cnt), .err_cnt(err_cnt), .outstanding(outstanding),
        .err_type(err_type), .err_dir(err_dir), .err_orphan(err_orphan),
        .err_overflow(err_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    typedef struct packed {
        logic [3:0]  typ;
        logic [3:0]  port;
        logic [31:0] addr;
        logic [31:0] data;
    } pkt_t;

    logic [7:0] m_buf [2][8];
    int         m_len [2];
    pkt_t       e_pkt [2];
    bit         e_valid [2];
    int         e_wr_req, e_rd_req, e_wr_ack, e_rd_ack, e_err, e_out;
    bit         e_type, e_dir, e_orphan, e_ovf;
    bit         m_live = 1'b0;

    function automatic int pkt_len(input logic [3:0] t);
        return 1 + AB + ((t == 4'd1 || t == 4'd3) ? DB : 0);
    endfunction

    function automatic int bump(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    // Collect bytes of one stream; report a finished packet or a rejected header.
    task automatic feed(input int s, input logic [7:0] b, output bit done, output bit bad,
                        output pkt_t p);
        logic [7:0] hdr;
        done = 1'b0;
        bad  = 1'b0;
        p    = '0;
        if (m_len[s] == 0) begin
            if (b == 8'h00) return;
            if (b[7:4] < 4'd1 || b[7:4] > 4'd4) begin
                bad = 1'b1;
                return;
            end
        end
        m_buf[s][m_len[s]] = b;
        m_len[s]++;
        hdr = m_buf[s][0];
        if (m_len[s] == pkt_len(hdr[7:4])) begin
            done   = 1'b1;
            p.typ  = hdr[7:4];
            p.port = hdr[3:0];
            for (int i = 1; i <= AB; i++) p.addr = (p.addr << 8) | 32'(m_buf[s][i]);
            for (int i = AB + 1; i < m_len[s]; i++) p.data = (p.data << 8) | 32'(m_buf[s][i]);
            m_len[s] = 0;
        end
    endtask

    always @(posedge clk) begin : model
        bit   d0, d1, b0, b1, req, ack, dirv, orph, ovf;
        pkt_t p0, p1;
        m_live = 1'b1;
        if (rst) begin
            m_len[0] = 0; m_len[1] = 0;
            e_pkt[0] = '0; e_pkt[1] = '0;
            e_valid[0] = 1'b0; e_valid[1] = 1'b0;
            e_wr_req = 0; e_rd_req = 0; e_wr_ack = 0; e_rd_ack = 0; e_err = 0; e_out = 0;
            e_type = 1'b0; e_dir = 1'b0; e_orphan = 1'b0; e_ovf = 1'b0;
        end else begin
            feed(0, fric_out, d0, b0, p0);
            feed(1, fric_in,  d1, b1, p1);
            e_valid[0] = d0;
            e_valid[1] = d1;
            if (d0) e_pkt[0] = p0;
            if (d1) e_pkt[1] = p1;
            req  = d0 && (p0.typ == 4'd1 || p0.typ == 4'd2);
            ack  = d1 && (p1.typ == 4'd3 || p1.typ == 4'd4);
            dirv = (d0 && !req) || (d1 && !ack);
            orph = 1'b0;
            ovf  = 1'b0;
            if (req && !ack) begin
                if (e_out == MO) ovf = 1'b1; else e_out = e_out + 1;
            end else if (ack && !req) begin
                if (e_out == 0) orph = 1'b1; else e_out = e_out - 1;
            end
            if (clear) begin
                e_wr_req = 0; e_rd_req = 0; e_wr_ack = 0; e_rd_ack = 0; e_err = 0;
                e_type = 1'b0; e_dir = 1'b0; e_orphan = 1'b0; e_ovf = 1'b0;
            end else begin
                if (req && p0.typ == 4'd1) e_wr_req = bump(e_wr_req);
                if (req && p0.typ == 4'd2) e_rd_req = bump(e_rd_req);
                if (ack && p1.typ == 4'd4) e_wr_ack = bump(e_wr_ack);
                if (ack && p1.typ == 4'd3) e_rd_ack = bump(e_rd_ack);
                if (b0 || b1 || dirv || orph || ovf) e_err = bump(e_err);
                if (b0 || b1) e_type   = 1'b1;
                if (dirv)     e_dir    = 1'b1;
                if (orph)     e_orphan = 1'b1;
                if (ovf)      e_ovf    = 1'b1;
            end
        end
    end

    // Compare every DUT output against the model on every falling edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("cmp o_valid", 32'(o_pkt_valid), 32'(e_valid[0]));
            check("cmp o_type",  32'(o_pkt_type),  32'(e_pkt[0].typ));
            check("cmp o_port",  32'(o_pkt_port),  32'(e_pkt[0].port));
            check("cmp o_addr",  32'(o_pkt_addr),  e_pkt[0].addr);
            check("cmp o_data",  32'(o_pkt_data),  e_pkt[0].data);
            check("cmp i_valid", 32'(i_pkt_valid), 32'(e_valid[1]));
            check("cmp i_type",  32'(i_pkt_type),  32'(e_pkt[1].typ));
            check("cmp i_port",  32'(i_pkt_port),  32'(e_pkt[1].port));
            check("cmp i_addr",  32'(i_pkt_addr),  e_pkt[1].addr);
            check("cmp i_data",  32'(i_pkt_data),  e_pkt[1].data);
            check("cmp wr_req_cnt", 32'(wr_req_cnt), 32'(e_wr_req));
            check("cmp rd_req_cnt", 32'(rd_req_cnt), 32'(e_rd_req));
            check("cmp wr_ack_cnt", 32'(wr_ack_cnt), 32'(e_wr_ack));
            check("cmp rd_ack_cnt", 32'(rd_ack_cnt), 32'(e_rd_ack));
            check("cmp err_cnt",    32'(err_cnt),    32'(e_err));
            check("cmp outstanding", 32'(outstanding), 32'(e_out));
            check("cmp err_type",     32'(err_type),     32'(e_type));
            check("cmp err_dir",      32'(err_dir),      32'(e_dir));
            check("cmp err_orphan",   32'(err_orphan),   32'(e_orphan));
            check("cmp err_overflow", 32'(err_overflow), 32'(e_ovf));
        end
    end

    // Drive one byte per stream, return at the next falling edge (outputs settled).
    task automatic step(input logic [7:0] ob, input logic [7:0] ib);
        fric_out = ob;
        fric_in  = ib;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; fric_out = 8'h00; fric_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst o_valid", 32'(o_pkt_valid), 32'd0);
        check("rst o_addr",  32'(o_pkt_addr),  32'd0);
        check("rst err_cnt", 32'(err_cnt),     32'd0);
        check("rst outstanding", 32'(outstanding), 32'd0);
        rst = 1'b0;

        // Write request.
        step(8'h13, 8'h00); step(8'h12, 8'h00); step(8'h34, 8'h00); step(8'hAB, 8'h00);
        check("wreq valid early", 32'(o_pkt_valid), 32'd0);
        step(8'hCD, 8'h00);
        check("wreq valid", 32'(o_pkt_valid), 32'd1);
        check("wreq type",  32'(o_pkt_type),  32'd1);
        check("wreq port",  32'(o_pkt_port),  32'd3);
        check("wreq addr",  32'(o_pkt_addr),  32'h1234);
        check("wreq data",  32'(o_pkt_data),  32'hABCD);
        check("wreq cnt",   32'(wr_req_cnt),  32'd1);
        check("wreq outstanding", 32'(outstanding), 32'd1);
        step(8'h00, 8'h00);
        check("wreq pulse width", 32'(o_pkt_valid), 32'd0);
        check("wreq addr hold",   32'(o_pkt_addr),  32'h1234);

        // Write ack.
        step(8'h00, 8'h43); step(8'h00, 8'h12); step(8'h00, 8'h34);
        check("wack valid", 32'(i_pkt_valid), 32'd1);
        check("wack type",  32'(i_pkt_type),  32'd4);
        check("wack cnt",   32'(wr_ack_cnt),  32'd1);
        check("wack outstanding", 32'(outstanding), 32'd0);

        // Orphan read ack with all-zero payload.
        step(8'h00, 8'h30);
        for (int i = 0; i < 3; i++) step(8'h00, 8'h00);
        check("orphan early", 32'(i_pkt_valid), 32'd0);
        step(8'h00, 8'h00);
        check("orphan valid", 32'(i_pkt_valid), 32'd1);
        check("orphan type",  32'(i_pkt_type),  32'd3);
        check("orphan flag",  32'(err_orphan),  32'd1);
        check("orphan errcnt", 32'(err_cnt),    32'd1);
        check("orphan outstanding", 32'(outstanding), 32'd0);

        // Bad header, then immediate recovery.
        step(8'h70, 8'h00);
        check("badhdr flag",   32'(err_type), 32'd1);
        check("badhdr errcnt", 32'(err_cnt),  32'd2);
        step(8'h21, 8'h00); step(8'hBE, 8'h00); step(8'hEF, 8'h00);
        check("recov valid", 32'(o_pkt_valid), 32'd1);
        check("recov type",  32'(o_pkt_type),  32'd2);
        check("recov port",  32'(o_pkt_port),  32'd1);
        check("recov addr",  32'(o_pkt_addr),  32'hBEEF);
        check("recov data",  32'(o_pkt_data),  32'd0);

        // Drain back to zero outstanding with a read ack.
        step(8'h00, 8'h30); step(8'h00, 8'h00); step(8'h00, 8'h00);
        step(8'h00, 8'h11); step(8'h00, 8'h22);
        check("drain outstanding", 32'(outstanding), 32'd0);

        // Five back-to-back read requests: fifth overflows.
        for (int k = 0; k < 5; k++) begin
            step(8'h20, 8'h00); step(8'h00, 8'h00); step(8'h10, 8'h00);
            if (k == 3) check("ovf at 4 flag", 32'(err_overflow), 32'd0);
        end
        check("ovf rd_req_cnt", 32'(rd_req_cnt),   32'd6);
        check("ovf outstanding", 32'(outstanding), 32'd4);
        check("ovf flag",       32'(err_overflow), 32'd1);
        check("ovf errcnt",     32'(err_cnt),      32'd3);

        // Two write acks bring outstanding to 2.
        for (int k = 0; k < 2; k++) begin
            step(8'h00, 8'h43); step(8'h00, 8'h00); step(8'h00, 8'h00);
        end
        check("pre-sim outstanding", 32'(outstanding), 32'd2);

        // Simultaneous request and ack completion.
        step(8'h20, 8'h43); step(8'h00, 8'h00); step(8'h10, 8'h10);
        check("sim o_valid", 32'(o_pkt_valid), 32'd1);
        check("sim i_valid", 32'(i_pkt_valid), 32'd1);
        check("sim outstanding", 32'(outstanding), 32'd2);
        check("sim errcnt", 32'(err_cnt), 32'd3);

        // Clear alone, then clear together with an error event.
        clear = 1'b1; step(8'h00, 8'h00); clear = 1'b0;
        check("clr rd_req_cnt", 32'(rd_req_cnt), 32'd0);
        check("clr ovf flag", 32'(err_overflow), 32'd0);
        check("clr outstanding", 32'(outstanding), 32'd2);
        clear = 1'b1; step(8'hF0, 8'h00); clear = 1'b0;
        check("clr+err flag",   32'(err_type), 32'd0);
        check("clr+err errcnt", 32'(err_cnt),  32'd0);

        // Ack type on the request stream: direction error, not counted.
        step(8'h40, 8'h00); step(8'h00, 8'h00); step(8'h00, 8'h00);
        check("dir flag",   32'(err_dir),    32'd1);
        check("dir wr_ack", 32'(wr_ack_cnt), 32'd0);
        check("dir outstanding", 32'(outstanding), 32'd2);

        // Saturate err_cnt with bad headers.
        for (int k = 0; k < 20; k++) step(8'hF0, 8'h00);
        check("sat errcnt", 32'(err_cnt), 32'(CMAX));

        // Reset in the middle of a write request, then a clean packet.
        step(8'h13, 8'h00); step(8'h12, 8'h00);
        rst = 1'b1; step(8'h34, 8'h00); rst = 1'b0;
        check("midrst valid",  32'(o_pkt_valid), 32'd0);
        check("midrst errcnt", 32'(err_cnt),     32'd0);
        check("midrst addr",   32'(o_pkt_addr),  32'd0);
        step(8'h15, 8'h00); step(8'hAA, 8'h00); step(8'hBB, 8'h00);
        step(8'h01, 8'h00); step(8'h02, 8'h00);
        check("post valid", 32'(o_pkt_valid), 32'd1);
        check("post port",  32'(o_pkt_port),  32'd5);
        check("post addr",  32'(o_pkt_addr),  32'hAABB);
        check("post data",  32'(o_pkt_data),  32'h0102);
        check("post outstanding", 32'(outstanding), 32'd1);
        step(8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
